// File: rtl/turtle_contact_pkg.sv
// Shared types and defaults for the turtle contact generator and its
// box-overlap helper.
package turtle_contact_pkg;

    localparam int COORD_W = 11;
    localparam int SUM_W   = COORD_W + 1;
    localparam int CD_W    = 8;

    localparam int DEFAULT_STOMP_MARGIN    = 4;
    localparam int DEFAULT_COOLDOWN_FRAMES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DECIDE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CONTACT_NONE  = 2'd0,
        CONTACT_STOMP = 2'd1,
        CONTACT_KICK  = 2'd2,
        CONTACT_HURT  = 2'd3
    } contact_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } box_t;

    // Far edge of a box, one bit wider so that x+w never wraps.
    function automatic logic [SUM_W-1:0] edge_sum(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/turtle_contact_gen_rect_overlap.sv
// Strict axis-aligned overlap test between two boxes; boxes that merely touch
// along an edge do not overlap.
module rect_overlap
    import turtle_contact_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic overlap
);

    logic left_ok;
    logic right_ok;
    logic top_ok;
    logic bottom_ok;

    assign left_ok   = {1'b0, a.x} < edge_sum(b.x, b.w);
    assign right_ok  = {1'b0, b.x} < edge_sum(a.x, a.w);
    assign top_ok    = {1'b0, a.y} < edge_sum(b.y, b.h);
    assign bottom_ok = {1'b0, b.y} < edge_sum(a.y, a.h);

    assign overlap = left_ok && right_ok && top_ok && bottom_ok;

endmodule

// File: rtl/turtle_contact_gen.sv
// Per-frame player/turtle contact classifier producing the toggle impulses the
// turtle sprite consumes plus one-cycle bounce/hurt pulses for the player.
module turtle_contact_gen
    import turtle_contact_pkg::*;
#(
    parameter int STOMP_MARGIN    = DEFAULT_STOMP_MARGIN,
    parameter int COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               enable,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] pw,
    input  logic [COORD_W-1:0] ph,
    input  logic [COORD_W-1:0] ex,
    input  logic [COORD_W-1:0] ey,
    input  logic [COORD_W-1:0] ew,
    input  logic [COORD_W-1:0] eh,
    input  logic               player_falling,
    input  logic               oriental,
    input  logic               shell,
    input  logic               shell_anim,
    input  logic               wall_left,
    input  logic               wall_right,
    output logic               collapsion_impulse,
    output logic               press_impulse,
    output logic               bounce,
    output logic               hurt
);

    state_t state;
    state_t state_next;

    box_t   p_box;
    box_t   e_box;
    logic   enable_q;
    logic   falling_q;
    logic   oriental_q;
    logic   shell_q;
    logic   shell_anim_q;
    logic   wall_left_q;
    logic   wall_right_q;

    logic [CD_W-1:0] cooldown;
    logic [CD_W-1:0] cooldown_dec;
    contact_t        contact_now;
    contact_t        contact_q;
    logic            wall_now;
    logic            wall_q;
    logic            overlap;
    logic            stomp_geom;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (frame_tick) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_DECIDE;
            ST_DECIDE:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Snapshot every input on the accepted tick so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_box        <= '0;
            e_box        <= '0;
            enable_q     <= 1'b0;
            falling_q    <= 1'b0;
            oriental_q   <= 1'b0;
            shell_q      <= 1'b0;
            shell_anim_q <= 1'b0;
            wall_left_q  <= 1'b0;
            wall_right_q <= 1'b0;
        end else if (state == ST_IDLE && frame_tick) begin
            p_box        <= '{x: px, y: py, w: pw, h: ph};
            e_box        <= '{x: ex, y: ey, w: ew, h: eh};
            enable_q     <= enable;
            falling_q    <= player_falling;
            oriental_q   <= oriental;
            shell_q      <= shell;
            shell_anim_q <= shell_anim;
            wall_left_q  <= wall_left;
            wall_right_q <= wall_right;
        end
    end

    rect_overlap u_rect_overlap (
        .a       (p_box),
        .b       (e_box),
        .overlap (overlap)
    );

    assign cooldown_dec = (cooldown != '0) ? cooldown - CD_W'(1) : '0;
    assign stomp_geom   = edge_sum(p_box.y, p_box.h) <= ({1'b0, e_box.y} + SUM_W'(STOMP_MARGIN));
    assign wall_now     = enable_q && (oriental_q ? wall_left_q : wall_right_q);

    // The cooldown gate looks at the already-decremented count.
    always_comb begin
        contact_now = CONTACT_NONE;
        if (enable_q && overlap && cooldown_dec == '0) begin
            if (falling_q && stomp_geom) begin
                contact_now = CONTACT_STOMP;
            end else if (shell_q && !shell_anim_q) begin
                contact_now = CONTACT_KICK;
            end else begin
                contact_now = CONTACT_HURT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cooldown  <= '0;
            contact_q <= CONTACT_NONE;
            wall_q    <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            cooldown  <= (contact_now != CONTACT_NONE) ? CD_W'(COOLDOWN_FRAMES) : cooldown_dec;
            contact_q <= contact_now;
            wall_q    <= wall_now;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bounce             <= 1'b0;
            hurt               <= 1'b0;
            press_impulse      <= 1'b0;
            collapsion_impulse <= 1'b0;
        end else begin
            bounce <= (state == ST_DECIDE) && (contact_q == CONTACT_STOMP);
            hurt   <= (state == ST_DECIDE) && (contact_q == CONTACT_HURT);
            if (state == ST_DECIDE) begin
                if (contact_q == CONTACT_STOMP || contact_q == CONTACT_KICK) begin
                    press_impulse <= ~press_impulse;
                end
                if (wall_q) begin
                    collapsion_impulse <= ~collapsion_impulse;
                end
            end
        end
    end

endmodule

// File: tb/tb_turtle_contact_gen.sv
// Randomized and directed self-checking bench for turtle_contact_gen against a
// frame-level behavioural model.
module tb_turtle_contact_gen;

    localparam int MARGIN = 4;
    localparam int CD     = 7;

    logic        clk;
    logic        rstn;
    logic        frame_tick;
    logic        enable;
    logic [10:0] px, py, pw, ph, ex, ey, ew, eh;
    logic        player_falling, oriental, shell, shell_anim, wall_left, wall_right;
    logic        collapsion_impulse, press_impulse, bounce, hurt;

    int vectors    = 0;
    int miscompares = 0;

    bit m_press;
    bit m_coll;
    int m_cd;

    turtle_contact_gen #(.STOMP_MARGIN(MARGIN), .COOLDOWN_FRAMES(CD)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .frame_tick         (frame_tick),
        .enable             (enable),
        .px                 (px),
        .py                 (py),
        .pw                 (pw),
        .ph                 (ph),
        .ex                 (ex),
        .ey                 (ey),
        .ew                 (ew),
        .eh                 (eh),
        .player_falling     (player_falling),
        .oriental           (oriental),
        .shell              (shell),
        .shell_anim         (shell_anim),
        .wall_left          (wall_left),
        .wall_right         (wall_right),
        .collapsion_impulse (collapsion_impulse),
        .press_impulse      (press_impulse),
        .bounce             (bounce),
        .hurt               (hurt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference: plain integer geometry, cooldown as frames remaining.
    task automatic model_step(output bit eb, output bit eh_o);
        int  pxi, pyi, pwi, phi, exi, eyi, ewi, ehi;
        bit  ov;
        pxi = int'(px); pyi = int'(py); pwi = int'(pw); phi = int'(ph);
        exi = int'(ex); eyi = int'(ey); ewi = int'(ew); ehi = int'(eh);
        ov = (pxi < exi + ewi) && (exi < pxi + pwi) && (pyi < eyi + ehi) && (eyi < pyi + phi);
        eb = 1'b0;
        eh_o = 1'b0;
        if (m_cd > 0) m_cd--;
        if (enable && ov && m_cd == 0) begin
            if (player_falling && (pyi + phi <= eyi + MARGIN)) begin
                m_press = !m_press;
                eb = 1'b1;
            end else if (shell && !shell_anim) begin
                m_press = !m_press;
            end else begin
                eh_o = 1'b1;
            end
            m_cd = CD;
        end
        if (enable && ((oriental && wall_left) || (!oriental && wall_right))) m_coll = !m_coll;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        m_press = 1'b0;
        m_coll = 1'b0;
        m_cd = 0;
    endtask

    task automatic set_scene(input int pxv, input int pyv, input int exv, input int eyv,
                             input bit fall, input bit sh, input bit sha);
        px = 11'(pxv); py = 11'(pyv); pw = 11'd16; ph = 11'd16;
        ex = 11'(exv); ey = 11'(eyv); ew = 11'd16; eh = 11'd24;
        player_falling = fall; shell = sh; shell_anim = sha;
        enable = 1'b1; oriental = 1'b0; wall_left = 1'b0; wall_right = 1'b0;
    endtask

    // Issues one tick and samples {bounce,hurt,press,collapsion} in DECIDE, after
    // the DECIDE->IDLE edge, and one cycle later.
    task automatic do_frame(input bit scramble, output logic [3:0] mid,
                            output logic [3:0] out, output logic [3:0] late);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (scramble) begin
            px = 11'($urandom); py = 11'($urandom); ex = 11'($urandom); ey = 11'($urandom);
            enable = 1'($urandom); wall_left = 1'($urandom); wall_right = 1'($urandom);
            oriental = 1'($urandom); player_falling = 1'($urandom); shell = 1'($urandom);
        end
        @(posedge clk);
        #1;
        mid = {bounce, hurt, press_impulse, collapsion_impulse};
        @(posedge clk);
        #1;
        out = {bounce, hurt, press_impulse, collapsion_impulse};
        @(posedge clk);
        #1;
        late = {bounce, hurt, press_impulse, collapsion_impulse};
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        apply_reset();
        obs = {bounce, hurt, press_impulse, collapsion_impulse};
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", obs);
        end
    endtask

    task automatic test_stomp();
        logic [3:0] mid, out, late;
        bit eb, eh_o;
        apply_reset();
        set_scene(100, 50, 100, 64, 1'b1, 1'b0, 1'b0);
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (mid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stomp_early: got %b expected 0000", mid);
        end
        vectors++;
        if (out !== 4'b1010 || out !== {eb, eh_o, m_press, m_coll}) begin
            miscompares++;
            $display("[TB] FAIL stomp_out: got %b expected 1010", out);
        end
        vectors++;
        if (late !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL stomp_pulse_width: got %b expected 0010", late);
        end
    endtask

    task automatic test_side_hit_cooldown();
        logic [3:0] mid, out, late;
        bit eb, eh_o, exp_h;
        apply_reset();
        set_scene(90, 70, 100, 64, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            model_step(eb, eh_o);
            do_frame(1'b0, mid, out, late);
            exp_h = (k == 0 || k == 7);
            vectors++;
            if (out !== {1'b0, exp_h, 2'b00} || eh_o !== exp_h) begin
                miscompares++;
                $display("[TB] FAIL side_hit_frame%0d: got %b expected %b", k, out, {1'b0, exp_h, 2'b00});
            end
            vectors++;
            if (late !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL side_hit_late%0d: got %b expected 0000", k, late);
            end
        end
    endtask

    task automatic test_kick();
        logic [3:0] mid, out, late;
        bit eb, eh_o;
        apply_reset();
        set_scene(90, 70, 100, 64, 1'b0, 1'b1, 1'b0);
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0010 || late !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL kick: got %b/%b expected 0010/0010", out, late);
        end
    endtask

    task automatic test_wall();
        logic [3:0] mid, out, late;
        bit eb, eh_o;
        apply_reset();
        set_scene(500, 500, 100, 64, 1'b0, 1'b0, 1'b0);
        oriental = 1'b1;
        wall_left = 1'b1;
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0001 || mid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL wall_toggle: got %b (mid %b) expected 0001 (mid 0000)", out, mid);
        end
        oriental = 1'b0;
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0001 || late !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL wall_no_retoggle: got %b expected 0001", out);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] mid, out, late;
        bit eb, eh_o;
        apply_reset();
        set_scene(100, 48, 100, 64, 1'b1, 1'b0, 1'b0);
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL touching_edge: got %b expected 0000", out);
        end
        set_scene(100, 70, 100, 64, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        oriental = 1'b1;
        wall_left = 1'b1;
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL disabled_overlap: got %b expected 0000", out);
        end
        set_scene(2040, 100, 4, 100, 1'b0, 1'b0, 1'b0);
        ew = 11'd2047;
        pw = 11'd20;
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL no_wrap_overlap: got %b expected 0100", out);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        bit eb, eh_o;
        apply_reset();
        set_scene(500, 500, 100, 64, 1'b0, 1'b0, 1'b0);
        wall_right = 1'b1;
        model_step(eb, eh_o);
        frame_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {bounce, hurt, press_impulse, collapsion_impulse};
        vectors++;
        if (obs !== {2'b00, m_press, m_coll}) begin
            miscompares++;
            $display("[TB] FAIL held_tick_single_event: got %b expected %b", obs, {2'b00, m_press, m_coll});
        end
    endtask

    task automatic test_reset_mid_decide();
        logic [3:0] mid, out, late, obs;
        bit eb, eh_o;
        apply_reset();
        set_scene(500, 500, 100, 64, 1'b0, 1'b0, 1'b0);
        oriental = 1'b1;
        wall_left = 1'b1;
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        set_scene(100, 50, 100, 64, 1'b1, 1'b0, 1'b0);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        obs = {bounce, hurt, press_impulse, collapsion_impulse};
        vectors++;
        if (obs !== 4'b0000 || late !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL async_reset_mid_decide: got %b (pre %b) expected 0000 (pre 0001)", obs, late);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_press = 1'b0;
        m_coll = 1'b0;
        m_cd = 0;
        repeat (2) @(posedge clk);
        #1;
        obs = {bounce, hurt, press_impulse, collapsion_impulse};
        vectors++;
        if (obs !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL after_abort_quiet: got %b expected 0000", obs);
        end
        set_scene(90, 70, 100, 64, 1'b0, 1'b0, 1'b0);
        model_step(eb, eh_o);
        do_frame(1'b0, mid, out, late);
        vectors++;
        if (out !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL cooldown_cleared_by_reset: got %b expected 0100", out);
        end
    endtask

    task automatic test_random();
        logic [3:0] mid, out, late;
        logic [1:0] prev;
        bit eb, eh_o;
        apply_reset();
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                px = 11'($urandom_range(1990, 2047)); ex = 11'($urandom_range(1990, 2047));
                pw = 11'($urandom_range(1, 2047));    ew = 11'($urandom_range(1, 2047));
            end else begin
                px = 11'($urandom_range(80, 130)); ex = 11'($urandom_range(90, 120));
                pw = 11'($urandom_range(4, 24));   ew = 11'($urandom_range(4, 24));
            end
            py = 11'($urandom_range(40, 100)); ph = 11'($urandom_range(4, 24));
            ey = 11'($urandom_range(50, 80));  eh = 11'($urandom_range(4, 32));
            enable = ($urandom_range(0, 7) != 0);
            player_falling = 1'($urandom); oriental = 1'($urandom);
            shell = 1'($urandom); shell_anim = 1'($urandom);
            wall_left = ($urandom_range(0, 3) == 0); wall_right = ($urandom_range(0, 3) == 0);
            prev = {m_press, m_coll};
            model_step(eb, eh_o);
            do_frame(1'b1, mid, out, late);
            vectors++;
            if (mid !== {2'b00, prev} || out !== {eb, eh_o, m_press, m_coll} ||
                late !== {2'b00, m_press, m_coll}) begin
                miscompares++;
                $display("[TB] FAIL random_frame%0d: got %b/%b/%b expected %b/%b/%b", n, mid, out, late,
                         {2'b00, prev}, {eb, eh_o, m_press, m_coll}, {2'b00, m_press, m_coll});
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        rstn = 1'b0;
        frame_tick = 1'b0;
        set_scene(500, 500, 100, 64, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_stomp();
        test_side_hit_cooldown();
        test_kick();
        test_wall();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_decide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/turtle_contact_gen.md
# turtle_contact_gen

Event generator feeding the turtle enemy's toggle-impulse inputs. Once per frame it compares the player and turtle bounding boxes plus the map's wall flags, and decides whether the turtle was stomped, kicked or hit a wall, or whether the player was hurt. It signals turtle events by toggling `collapsion_impulse` and `press_impulse`, the encoding the turtle sprite block consumes. It also emits single-cycle `bounce` and `hurt` pulses for the player controller. It sits between the position/physics logic and the turtle sprite instance.

## Interface
Parameters:
- `STOMP_MARGIN`, 4: pixels below the turtle top that still count as a stomp.
- `COOLDOWN_FRAMES`, 8: frames (1..255) during which player contact events are suppressed after any contact event.

Ports:
- `clk`  in  1: system clock.
- `rstn`  in  1: reset; asynchronous, active-low.
- `frame_tick`  in  1: one-cycle pulse, once per video frame.
- `enable`  in  1: turtle alive and shown; low suppresses all events.
- `px`, `py`, `pw`, `ph`  in  11 each: player box (x, y top-left, width, height; y grows downward).
- `ex`, `ey`, `ew`, `eh`  in  11 each: turtle box.
- `player_falling`  in  1: player vertical velocity is downward.
- `oriental`  in  1: turtle heading; 0 right, 1 left.
- `shell`, `shell_anim`  in  1 each: turtle is in shell; shell is sliding.
- `wall_left`, `wall_right`  in  1 each: turtle box touches solid tile on that side.
- `collapsion_impulse`  out  1: toggles once per wall-reversal event.
- `press_impulse`  out  1: toggles once per stomp or kick event.
- `bounce`  out  1: one-cycle pulse; player must rebound.
- `hurt`  out  1: one-cycle pulse; player takes damage.

## Operation
- FSM has three states: IDLE, CAPTURE, DECIDE.
  - IDLE → CAPTURE on `frame_tick`; all inputs are latched in that cycle.
  - CAPTURE → DECIDE unconditionally; the overlap and classification results are registered.
  - DECIDE → IDLE unconditionally; outputs are updated.
- A `frame_tick` arriving in CAPTURE or DECIDE is ignored; it does not advance the cooldown.
- Overlap uses strict inequality on all four sides: `px < ex+ew`, `ex < px+pw`, `py < ey+eh`, `ey < py+ph`. All sums are computed at 12 bits, with no wrap.
- Contact is classified when overlap holds, `enable` is 1 and the cooldown is 0:
  - Stomp: `player_falling` and `py+ph <= ey+STOMP_MARGIN`. Toggle `press_impulse` and pulse `bounce`.
  - Kick: not a stomp, `shell`=1, `shell_anim`=0. Toggle `press_impulse`; no `hurt`.
  - Hurt: neither of the above. Pulse `hurt`.
  - Any contact event loads the cooldown with `COOLDOWN_FRAMES`.
- Wall rule, evaluated independently of the cooldown with `enable`=1: (`oriental`=1 and `wall_left`) or (`oriental`=0 and `wall_right`) toggles `collapsion_impulse`. At most one wall toggle per frame.
- Wall and contact events in the same frame both fire.
- The cooldown decrements by 1 in every CAPTURE whose latched value is nonzero. The decrement happens before classification, so `COOLDOWN_FRAMES`=N blocks exactly the next N−1 frames.

## Timing
- Reset values:
  - state IDLE, cooldown 0.
  - `collapsion_impulse`=0, `press_impulse`=0, `bounce`=0, `hurt`=0.
- Latency: toggles and pulses appear 2 cycles after the `frame_tick` cycle and are visible from the DECIDE→IDLE edge.
- `bounce`/`hurt` are high for exactly 1 cycle. The impulse outputs hold their level between events.
- Reset mid-operation aborts immediately and returns every output to its reset value. The consumer resynchronises its `pre_*` copies during its own reset.
- Changes to `enable` are only sampled at CAPTURE.

## Structure
- Shared package: coordinate width 11, state encoding, default `STOMP_MARGIN`/`COOLDOWN_FRAMES`.
- One combinational sub-module, `rect_overlap`, takes two boxes and returns `overlap`. It is reused by the coin and mushroom contact logic.

## Test plan
- Stomp: player (100,50,16,16) falling, turtle (100,64,16,24), tick → `press_impulse` 0→1 and `bounce` 1 cycle at tick+2; no `hurt`.
- Side hit: player (90,70,16,16), turtle (100,64,16,24), `shell`=0, tick → `hurt` pulse; impulses unchanged. The same setup on the next 6 ticks gives no `hurt`; the tick after those gives `hurt` again.
- Kick: as side hit but `shell`=1, `shell_anim`=0 → `press_impulse` toggles, no `hurt`.
- Wall: `oriental`=1, `wall_left`=1, player far away → `collapsion_impulse` toggles once. With `oriental`=0 on the next tick, no further toggle.
- Reset: assert `rstn`=0 during DECIDE of a stomp frame → all outputs 0 asynchronously. Touching boxes (`py+ph`=`ey`) give no event; `enable`=0 with full overlap gives no event.
